// File: rtl/cache_fill_ctrl.sv
// Cache-line fill controller: per-word reads with a bounded number of outstanding requests.
// Define CRITICAL_WORD_FIRST_EN to start each fill at the missed word and wrap around the line.
module cache_fill_ctrl #(
  parameter int ADDR_W          = 16,
  parameter int WORD_BYTES      = 2,
  parameter int WORDS_PER_LINE  = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_detected,
  input  logic [ADDR_W-1:0]                 miss_address,
  input  logic                              mem_ready,
  input  logic                              memory_data_valid,
  output logic                              fsm_busy,
  output logic                              mem_req,
  output logic [ADDR_W-1:0]                 memory_address,
  output logic                              write_data_array,
  output logic [$clog2(WORDS_PER_LINE)-1:0] data_word_sel,
  output logic                              write_tag_array,
  output logic                              fill_done
);

  localparam int SEL_W = $clog2(WORDS_PER_LINE);
  localparam int CNT_W = SEL_W + 1;
  localparam int WB_SH = $clog2(WORD_BYTES);
  localparam int OFF_W = $clog2(WORD_BYTES * WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] MAX_OUT    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] LAST_RSP   = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // state  | meaning
  // S_IDLE | waiting for a miss
  // S_FILL | issuing requests and writing returned words
  // S_DONE | one-cycle fill_done pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [CNT_W-1:0]   r_rsp_cnt;
  logic [SEL_W-1:0]   r_crit;
  logic               r_busy;
  logic               r_done;

  logic [CNT_W-1:0]   w_outstanding;
  logic               w_req;
  logic               w_accept;
  logic               w_rsp;
  logic               w_last_rsp;
  logic [SEL_W-1:0]   w_req_idx;
  logic [SEL_W-1:0]   w_rsp_idx;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [ADDR_W-1:0]  w_base_next;
  logic               w_unused_offset;

  assign w_outstanding = r_req_cnt - r_rsp_cnt;
  assign w_req         = (r_state == S_FILL) && (r_req_cnt < LINE_WORDS) && (w_outstanding < MAX_OUT);
  assign w_accept      = w_req && mem_ready;
  assign w_rsp         = (r_state == S_FILL) && memory_data_valid && (w_outstanding != '0);
  assign w_last_rsp    = (r_rsp_cnt == LAST_RSP);

  // Index arithmetic is SEL_W wide so the rotated order wraps inside the line.
  assign w_req_idx     = r_crit + r_req_cnt[SEL_W-1:0];
  assign w_rsp_idx     = r_crit + r_rsp_cnt[SEL_W-1:0];
  assign w_req_addr    = r_base + (ADDR_W'(w_req_idx) << WB_SH);
  assign w_base_next   = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unused_offset = ^miss_address[OFF_W-1:0];

  assign fsm_busy         = r_busy;
  assign fill_done        = r_done;
  assign mem_req          = w_req;
  assign memory_address   = w_req ? w_req_addr : r_last_addr;
  assign write_data_array = w_rsp;
  assign data_word_sel    = w_rsp_idx;
  assign write_tag_array  = w_rsp && w_last_rsp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_last_addr <= '0;
      r_req_cnt   <= '0;
      r_rsp_cnt   <= '0;
      r_crit      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_state   <= S_FILL;
            r_base    <= w_base_next;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_busy    <= 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
            r_crit    <= miss_address[OFF_W-1:WB_SH];
`else
            r_crit    <= '0;
`endif
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_req_cnt   <= r_req_cnt + CNT_ONE;
            r_last_addr <= w_req_addr;
          end
          if (w_rsp) begin
            r_rsp_cnt <= r_rsp_cnt + CNT_ONE;
            if (w_last_rsp) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
